// File: rtl/fib_seq_buffer_pkg.sv
// Shared types and constants for the Fibonacci term buffer.
package fib_pkg;
  localparam int FIB_W = 6;

  typedef enum logic {
    CAPTURE = 1'b0,
    HOLD    = 1'b1
  } fib_buf_state_t;
endpackage

// File: rtl/fib_seq_buffer_if.sv
// Term stream in, FWFT head out; the buffer is the slave on both sides.
interface fib_seq_buffer_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fib_seq_buffer_fifo.sv
// First-word-fall-through FIFO; the caller gates push/pop against full/empty.
module fib_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO masks the head to zero instead.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fib_seq_buffer.sv
// Buffers generator terms, flags 6-bit wrap-around and optionally freezes capture on it.
module fib_seq_buffer
  import fib_pkg::*;
#(
  parameter int WIDTH        = FIB_W,
  parameter int DEPTH        = 8,
  parameter bit STOP_ON_WRAP = 1'b1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clear,
  fib_seq_buffer_if.slave bus,
  output logic [CW-1:0]   o_count,
  output logic            o_wrap,
  output logic [7:0]      o_term_idx,
  output logic            o_state
);
  fib_buf_state_t   r_state;
  fib_buf_state_t   w_state_nxt;
  logic             r_wrap;
  logic             r_prev_valid;
  logic [WIDTH-1:0] r_prev;
  logic [7:0]       r_term_idx;
  logic [CW-1:0]    w_count;
  logic             w_srst;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_is_wrap;

  assign w_srst      = i_rst | i_clear;
  assign w_in_ready  = (r_state == CAPTURE) && (w_count != CW'(DEPTH));
  assign w_out_valid = (w_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_is_wrap   = r_prev_valid && (bus.in_data < r_prev);

  fib_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_clr   (w_srst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.in_data),
    .o_data  (bus.out_data),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk) begin
    if (w_srst) begin
      r_wrap       <= 1'b0;
      r_prev_valid <= 1'b0;
      r_prev       <= '0;
      r_term_idx   <= '0;
    end else if (w_push) begin
      if (w_is_wrap) r_wrap <= 1'b1;
      r_prev       <= bus.in_data;
      r_prev_valid <= 1'b1;
      if (r_term_idx != 8'hFF) r_term_idx <= r_term_idx + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_srst) r_state <= CAPTURE;
    else        r_state <= w_state_nxt;
  end

  // HOLD is absorbing; only reset or clear brings capture back.
  always_comb begin
    w_state_nxt = r_state;
    if (STOP_ON_WRAP && (r_state == CAPTURE) && w_push && w_is_wrap)
      w_state_nxt = HOLD;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign o_count       = w_count;
  assign o_wrap        = r_wrap;
  assign o_term_idx    = r_term_idx;
  assign o_state       = r_state;
endmodule
